// File: rtl/mdio_slave.sv
// Clause-22 MDIO responder with a 32 x 16-bit register file.
// MDC/MDIO are oversampled on clk; all decoding happens on the synced MDC rising edge.
module mdio_slave #(
  parameter logic [4:0]  PHY_ADDRESS   = 5'h0c,
  parameter int unsigned PREAMBLE_BITS = 32,
  parameter logic [15:0] PHY_ID1       = 16'h0022,
  parameter logic [15:0] PHY_ID2       = 16'h1622
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic [15:0] bmsr_in,
  output logic        reg_wr_valid,
  output logic [4:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data
);

  localparam int unsigned PW = $clog2(PREAMBLE_BITS + 1);
  localparam logic [PW-1:0] PreMax = PW'(PREAMBLE_BITS);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StOp    = 3'd2;
  localparam logic [2:0] StPhy   = 3'd3;
  localparam logic [2:0] StReg   = 3'd4;
  localparam logic [2:0] StTa    = 3'd5;
  localparam logic [2:0] StRd    = 3'd6;
  localparam logic [2:0] StWr    = 3'd7;

  logic [1:0]    mdc_sync_q, mdio_sync_q;
  logic          mdc_prev_q;
  logic [2:0]    state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          op_read_q, op_read_d;
  logic          ignore_q, ignore_d;
  logic [4:0]    adr_q, adr_d;
  logic [15:0]   shift_q, shift_d;
  logic          mdio_o_q, mdio_o_d, mdio_t_q, mdio_t_d;
  logic          wr_valid_q, wr_valid_d;
  logic [4:0]    wr_addr_q, wr_addr_d;
  logic [15:0]   wr_data_q, wr_data_d;
  logic [15:0]   regs_q [32];
  logic [15:0]   regs_d [32];
  logic          rise, bit_in;
  logic [15:0]   rd_data, wr_word;
  logic          ro_reg;

  assign rise    = mdc_sync_q[1] & ~mdc_prev_q;
  assign bit_in  = mdio_sync_q[1];
  assign wr_word = {shift_q[14:0], bit_in};
  assign ro_reg  = (adr_q == 5'd1) || (adr_q == 5'd2) || (adr_q == 5'd3);

  always_comb begin
    unique case (adr_q)
      5'd1:    rd_data = bmsr_in;
      5'd2:    rd_data = PHY_ID1;
      5'd3:    rd_data = PHY_ID2;
      default: rd_data = regs_q[adr_q];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    cnt_d      = cnt_q;
    op_read_d  = op_read_q;
    ignore_d   = ignore_q;
    adr_d      = adr_q;
    shift_d    = shift_q;
    mdio_o_d   = mdio_o_q;
    mdio_t_d   = mdio_t_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    regs_d     = regs_q;
    if (rise) begin
      unique case (state_q)
        StIdle: begin
          if (bit_in) begin
            if (pre_q != PreMax) pre_d = pre_q + 1'b1;
          end else begin
            if (pre_q == PreMax) state_d = StStart;
            pre_d = '0;
          end
        end
        StStart: begin
          state_d = bit_in ? StOp : StIdle;
          cnt_d   = '0;
        end
        StOp: begin
          if (cnt_q == 4'd0) begin
            op_read_d = bit_in;
            cnt_d     = 4'd1;
          end else if (op_read_q != bit_in) begin
            state_d  = StPhy;
            cnt_d    = '0;
            ignore_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
        StPhy, StReg: begin
          adr_d = {adr_q[3:0], bit_in};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == 4'd4) begin
            cnt_d   = '0;
            state_d = (state_q == StPhy) ? StReg : StTa;
            if (state_q == StPhy) ignore_d = ({adr_q[3:0], bit_in} != PHY_ADDRESS);
          end
        end
        StTa: begin
          if (op_read_q) begin
            if (cnt_q == 4'd0) begin
              // TA zero; read data is frozen here so bmsr_in cannot tear mid-frame.
              shift_d = rd_data;
              cnt_d   = 4'd1;
              if (!ignore_q) begin
                mdio_t_d = 1'b0;
                mdio_o_d = 1'b0;
              end
            end else begin
              if (!ignore_q) mdio_o_d = shift_q[15];
              shift_d = shift_q << 1;
              state_d = StRd;
              cnt_d   = '0;
            end
          end else if (cnt_q == 4'd0) begin
            if (bit_in) cnt_d = 4'd1;
            else        state_d = StIdle;
          end else begin
            state_d = bit_in ? StIdle : StWr;
            cnt_d   = '0;
          end
        end
        StRd: begin
          if (cnt_q == 4'd15) begin
            mdio_t_d = 1'b1;
            mdio_o_d = 1'b0;
            state_d  = StIdle;
          end else begin
            if (!ignore_q) mdio_o_d = shift_q[15];
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        default: begin // StWr
          shift_d = wr_word;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == 4'd15) begin
            state_d = StIdle;
            if (!ignore_q && !ro_reg) begin
              regs_d[adr_q] = wr_word;
              wr_valid_d    = 1'b1;
              wr_addr_d     = adr_q;
              wr_data_d     = wr_word;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '0;
      mdc_prev_q  <= 1'b0;
      state_q     <= StIdle;
      pre_q       <= '0;
      cnt_q       <= '0;
      op_read_q   <= 1'b0;
      ignore_q    <= 1'b0;
      adr_q       <= '0;
      shift_q     <= '0;
      mdio_o_q    <= 1'b0;
      mdio_t_q    <= 1'b1;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[0], mdc};
      mdio_sync_q <= {mdio_sync_q[0], mdio_i};
      mdc_prev_q  <= mdc_sync_q[1];
      state_q     <= state_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      op_read_q   <= op_read_d;
      ignore_q    <= ignore_d;
      adr_q       <= adr_d;
      shift_q     <= shift_d;
      mdio_o_q    <= mdio_o_d;
      mdio_t_q    <= mdio_t_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
    end
  end

  assign mdio_o       = mdio_o_q;
  assign mdio_t       = mdio_t_q;
  assign reg_wr_valid = wr_valid_q;
  assign reg_wr_addr  = wr_addr_q;
  assign reg_wr_data  = wr_data_q;

endmodule

// File: tb/tb_mdio_slave.sv
// Directed bench for mdio_slave: the bench acts as MDIO master with a pulled-up pad.
module tb_mdio_slave;

  logic        clk = 1'b0;
  logic        reset, mdc, mdio_i;
  logic        mdio_o, mdio_t;
  logic [15:0] bmsr_in;
  logic        reg_wr_valid;
  logic [4:0]  reg_wr_addr;
  logic [15:0] reg_wr_data;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_pulses = 0;
  int t_low = 0;

  mdio_slave dut (
    .clk          (clk),
    .reset        (reset),
    .mdc          (mdc),
    .mdio_i       (mdio_i),
    .mdio_o       (mdio_o),
    .mdio_t       (mdio_t),
    .bmsr_in      (bmsr_in),
    .reg_wr_valid (reg_wr_valid),
    .reg_wr_addr  (reg_wr_addr),
    .reg_wr_data  (reg_wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reg_wr_valid) wr_pulses <= wr_pulses + 1;
    if (!mdio_t)      t_low <= t_low + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One MDC period (16 clk); the pad is sampled just before the rising edge.
  task automatic mbit(input logic b, output logic pad);
    mdio_i = b;
    #79;
    pad = mdio_t ? 1'b1 : mdio_o;
    #1 mdc = 1'b1;
    #80 mdc = 1'b0;
  endtask

  task automatic send_hdr(input int npre, input logic [1:0] op, input logic [4:0] phy,
                          input logic [4:0] ra);
    logic p;
    for (int i = 0; i < npre; i++) mbit(1'b1, p);
    mbit(1'b0, p);
    mbit(1'b1, p);
    mbit(op[1], p);
    mbit(op[0], p);
    for (int i = 4; i >= 0; i--) mbit(phy[i], p);
    for (int i = 4; i >= 0; i--) mbit(ra[i], p);
  endtask

  task automatic wr_frame(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d,
                          input logic [1:0] op, input logic [1:0] ta);
    logic p;
    send_hdr(32, op, phy, ra);
    mbit(ta[1], p);
    mbit(ta[0], p);
    for (int i = 15; i >= 0; i--) mbit(d[i], p);
  endtask

  task automatic rd_frame(input int npre, input logic [4:0] phy, input logic [4:0] ra,
                          output logic [15:0] d, output logic ta0, output int low);
    logic p;
    int base;
    send_hdr(npre, 2'b10, phy, ra);
    base = t_low;
    for (int j = 0; j < 18; j++) begin
      mbit(1'b1, p);
      if (j == 1) ta0 = p;
      if (j >= 2) d[17-j] = p;
    end
    #40;
    low = t_low - base;
  endtask

  logic [15:0] rd;
  logic        ta0, p;
  int          low, pulses0;

  initial begin
    reset = 1'b0; mdc = 1'b0; mdio_i = 1'b1; bmsr_in = 16'h0000;
    #3;
    #40;
    check("rst_mdio_t", {31'd0, mdio_t}, 32'd1);
    check("rst_mdio_o", {31'd0, mdio_o}, 32'd0);
    check("rst_wr", {reg_wr_valid, reg_wr_addr, reg_wr_data}, 32'd0);
    reset = 1'b1;
    #40;

    // Write 0xA5C3 to reg 0x10, then read it back
    pulses0 = wr_pulses;
    wr_frame(5'h0c, 5'h10, 16'hA5C3, 2'b01, 2'b10);
    check("wr_pulse_cnt", wr_pulses - pulses0, 32'd1);
    check("wr_addr", {27'd0, reg_wr_addr}, 32'h10);
    check("wr_data", {16'd0, reg_wr_data}, 32'hA5C3);
    rd_frame(32, 5'h0c, 5'h10, rd, ta0, low);
    check("rd_r10", {16'd0, rd}, 32'hA5C3);
    check("rd_ta0", {31'd0, ta0}, 32'd0);
    check("rd_t_low", low, 32'd272);

    // ID and live status registers
    bmsr_in = 16'h7809;
    rd_frame(32, 5'h0c, 5'h02, rd, ta0, low);
    check("rd_id1", {16'd0, rd}, 32'h0022);
    check("rd_id1_t_low", low, 32'd272);
    rd_frame(32, 5'h0c, 5'h01, rd, ta0, low);
    check("rd_bmsr", {16'd0, rd}, 32'h7809);

    // Frames to another PHY are ignored
    pulses0 = wr_pulses;
    wr_frame(5'h0d, 5'h10, 16'h1234, 2'b01, 2'b10);
    check("other_wr_pulse", wr_pulses - pulses0, 32'd0);
    rd_frame(32, 5'h0d, 5'h10, rd, ta0, low);
    check("other_rd_data", {16'd0, rd}, 32'hFFFF);
    check("other_rd_t_low", low, 32'd0);
    rd_frame(32, 5'h0c, 5'h10, rd, ta0, low);
    check("after_other_r10", {16'd0, rd}, 32'hA5C3);

    // Short preamble gets no answer
    rd_frame(31, 5'h0c, 5'h10, rd, ta0, low);
    check("pre31_data", {16'd0, rd}, 32'hFFFF);
    check("pre31_t_low", low, 32'd0);
    rd_frame(32, 5'h0c, 5'h10, rd, ta0, low);
    check("pre32_data", {16'd0, rd}, 32'hA5C3);

    // Discarded writes: bad TA, bad opcode, read-only register
    pulses0 = wr_pulses;
    wr_frame(5'h0c, 5'h10, 16'h5555, 2'b01, 2'b11);
    wr_frame(5'h0c, 5'h10, 16'h6666, 2'b11, 2'b10);
    wr_frame(5'h0c, 5'h03, 16'h7777, 2'b01, 2'b10);
    check("discard_pulses", wr_pulses - pulses0, 32'd0);
    rd_frame(32, 5'h0c, 5'h10, rd, ta0, low);
    check("discard_r10", {16'd0, rd}, 32'hA5C3);
    rd_frame(32, 5'h0c, 5'h03, rd, ta0, low);
    check("discard_r3", {16'd0, rd}, 32'h1622);

    // Reset while data bit 8 is being driven
    send_hdr(32, 2'b10, 5'h0c, 5'h10);
    for (int j = 0; j < 9; j++) mbit(1'b1, p);
    check("mid_rd_driving", {31'd0, mdio_t}, 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_t", {31'd0, mdio_t}, 32'd1);
    #19;
    reset = 1'b1;
    #80;
    rd_frame(32, 5'h0c, 5'h10, rd, ta0, low);
    check("post_rst_r10", {16'd0, rd}, 32'h0000);
    check("post_rst_t_low", low, 32'd272);
    pulses0 = wr_pulses;
    wr_frame(5'h0c, 5'h05, 16'hBEEF, 2'b01, 2'b10);
    check("post_rst_wr_pulse", wr_pulses - pulses0, 32'd1);
    rd_frame(32, 5'h0c, 5'h05, rd, ta0, low);
    check("post_rst_r5", {16'd0, rd}, 32'hBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
